// File: rtl/sobel_pkg.sv
// Shared definitions for the front end of the sobel pipeline: the
// byte-stream FSM states, header length and the integer luma weights.
package sobel_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        PIX_R  = 3'd2,
        PIX_G  = 3'd3,
        PIX_B  = 3'd4
    } state_t;

    // Width lo/hi followed by height lo/hi.
    localparam int HEADER_BYTES = 4;

    // BT.601-style weights scaled by 256; they sum to 256, so a full-scale
    // pixel gives 255*256 and the 16-bit sum never overflows.
    localparam logic [15:0] LUMA_R     = 16'd77;
    localparam logic [15:0] LUMA_G     = 16'd150;
    localparam logic [15:0] LUMA_B     = 16'd29;
    localparam int          LUMA_SHIFT = 8;

endpackage

// File: rtl/luma_calc.sv
// Combinational RGB -> 8-bit gray conversion using fixed-point weights.
module luma_calc
    import sobel_pkg::*;
(
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] gray
);

    logic [15:0] sum;

    // Weighted sum then drop the fractional byte; max result is 255.
    always_comb begin
        sum  = (LUMA_R * {8'd0, r}) + (LUMA_G * {8'd0, g}) + (LUMA_B * {8'd0, b});
        gray = 8'(sum >> LUMA_SHIFT);
    end

endmodule

// File: rtl/rgb_to_gray.sv
// Stream front end: forwards the 4-byte frame header, then collapses each
// R,G,B triple into one gray byte. A single output register with
// ready_in = !valid_out || ready_out gives full throughput and a stable
// output while downstream stalls. frame_done pulses with the load of the
// last byte of a frame.
module rgb_to_gray
    import sobel_pkg::*;
#(
    parameter int DATA_BITS_IN = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_BITS_IN-1:0] data_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [DATA_BITS_IN-1:0] data_out,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic                    frame_done
);

    state_t      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [31:0] pixel_total_q, pixel_total_d;
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        frame_done_q, frame_done_d;

    logic        in_fire;
    logic        load;
    logic [7:0]  load_data;
    logic [7:0]  gray;
    logic [31:0] pix_cnt_next;

    luma_calc u_luma (
        .r    (r_q),
        .g    (g_q),
        .b    (data_in),
        .gray (gray)
    );

    assign ready_in   = !valid_out_q || ready_out;
    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

    // Next-state, header capture, pixel counting and output register load.
    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        width_d       = width_q;
        height_d      = height_q;
        pixel_total_d = pixel_total_q;
        pix_cnt_d     = pix_cnt_q;
        r_d           = r_q;
        g_d           = g_q;
        data_out_d    = data_out_q;
        valid_out_d   = valid_out_q && !ready_out;
        frame_done_d  = 1'b0;
        load          = 1'b0;
        load_data     = data_in;
        in_fire       = valid_in && ready_in;
        pix_cnt_next  = pix_cnt_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    load          = 1'b1;
                    width_d[7:0]  = data_in;
                    hdr_cnt_d     = 2'd1;
                    state_d       = HEADER;
                end
            end
            HEADER: begin
                if (in_fire) begin
                    load      = 1'b1;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd1) begin
                        width_d[15:8] = data_in;
                    end else if (hdr_cnt_q == 2'd2) begin
                        height_d[7:0] = data_in;
                    end else begin
                        // Last header byte: the product is ready before any pixel arrives.
                        height_d      = {data_in, height_q[7:0]};
                        pixel_total_d = 32'(width_q) * 32'(height_d);
                    end
                    if (hdr_cnt_q == 2'(HEADER_BYTES - 1)) begin
                        hdr_cnt_d = 2'd0;
                        pix_cnt_d = 32'd0;
                        if (pixel_total_d == 32'd0) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            state_d = PIX_R;
                        end
                    end
                end
            end
            PIX_R: begin
                if (in_fire) begin
                    r_d     = data_in;
                    state_d = PIX_G;
                end
            end
            PIX_G: begin
                if (in_fire) begin
                    g_d     = data_in;
                    state_d = PIX_B;
                end
            end
            PIX_B: begin
                if (in_fire) begin
                    load      = 1'b1;
                    load_data = gray;
                    if (pix_cnt_next == pixel_total_q) begin
                        pix_cnt_d    = 32'd0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        pix_cnt_d = pix_cnt_next;
                        state_d   = PIX_R;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            valid_out_d = 1'b1;
            data_out_d  = load_data;
        end
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hdr_cnt_q     <= 2'd0;
            width_q       <= 16'd0;
            height_q      <= 16'd0;
            pixel_total_q <= 32'd0;
            pix_cnt_q     <= 32'd0;
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            data_out_q    <= 8'd0;
            valid_out_q   <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            width_q       <= width_d;
            height_q      <= height_d;
            pixel_total_q <= pixel_total_d;
            pix_cnt_q     <= pix_cnt_d;
            r_q           <= r_d;
            g_q           <= g_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            frame_done_q  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_rgb_to_gray.sv
// Bench for rgb_to_gray: directed byte streams, expected output bytes
// (with their frame_done flag) queued at stimulus time and checked by an
// independent monitor on every output transfer.
module tb_rgb_to_gray;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_out;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_fd = 0;
    int fd_seen = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic shown = 1'b0;
    logic fd_at_load = 1'b0;

    rgb_to_gray #(.DATA_BITS_IN(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .frame_done (frame_done)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] d, input logic fd);
        exp_q.push_back({fd, d});
        if (fd) exp_fd++;
    endtask

    // Present one byte and hold it until the DUT takes it; returns at posedge+1.
    task automatic send(input logic [7:0] b);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        data_in  = b;
        valid_in = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            got = ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted byte=%0h", b);
        end
    endtask

    task automatic idle();
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: capture frame_done at load, compare on each output transfer.
    always @(negedge clk) begin
        if (rst) begin
            shown = 1'b0;
        end else begin
            if (frame_done) fd_seen++;
            if (valid_out && !shown) begin
                fd_at_load = frame_done;
                shown      = 1'b1;
            end
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=none", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", 32'(data_out), 32'(mon_e[7:0]));
                    chk("out_frame_done", 32'(fd_at_load), 32'(mon_e[8]));
                end
                shown = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        data_in   = 8'h00;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_in", 32'(ready_in), 1);
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 2x2 frame: white, red, green, blue.
        expect_out(8'h02, 0); expect_out(8'h00, 0); expect_out(8'h02, 0); expect_out(8'h00, 0);
        expect_out(8'hFF, 0); expect_out(8'h4C, 0); expect_out(8'h95, 0); expect_out(8'h1C, 1);
        send(8'h02); send(8'h00); send(8'h02); send(8'h00);
        send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'hFF); send(8'h00); send(8'h00);
        send(8'h00); send(8'hFF); send(8'h00);
        send(8'h00); send(8'h00); send(8'hFF);
        idle();
        drain();

        // Empty frame (1x0): header only, then the next byte starts a new header.
        expect_out(8'h01, 0); expect_out(8'h00, 0); expect_out(8'h00, 0); expect_out(8'h00, 1);
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        idle();
        drain();
        expect_out(8'h05, 0); expect_out(8'h00, 0); expect_out(8'h00, 0); expect_out(8'h00, 1);
        send(8'h05); send(8'h00); send(8'h00); send(8'h00);
        idle();
        drain();

        // Downstream stall on the first header byte, then a 2x1 frame.
        expect_out(8'h02, 0); expect_out(8'h00, 0); expect_out(8'h01, 0); expect_out(8'h00, 0);
        expect_out(8'h1D, 0); expect_out(8'h80, 1);
        ready_out = 1'b0;
        send(8'h02);
        data_in  = 8'h00;
        valid_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_data_out", 32'(data_out), 32'h02);
            chk("stall_valid_out", 32'(valid_out), 1);
            chk("stall_ready_in", 32'(ready_in), 0);
            @(posedge clk);
            #1;
        end
        ready_out = 1'b1;
        send(8'h00); send(8'h01); send(8'h00);
        send(8'h10); send(8'h20); send(8'h30);
        send(8'h80); send(8'h80); send(8'h80);
        idle();
        drain();

        // 1x1 frame streamed back to back: one byte accepted per cycle.
        begin
            int t0;
            expect_out(8'h01, 0); expect_out(8'h00, 0); expect_out(8'h01, 0); expect_out(8'h00, 0);
            expect_out(8'h1D, 1);
            t0 = cyc;
            send(8'h01); send(8'h00); send(8'h01); send(8'h00);
            send(8'h10); send(8'h20); send(8'h30);
            chk("stream_cycles", 32'(cyc - t0), 7);
            idle();
            drain();
        end

        // Reset after the G byte of pixel 2 of a 1x2 frame.
        expect_out(8'h01, 0); expect_out(8'h00, 0); expect_out(8'h02, 0); expect_out(8'h00, 0);
        expect_out(8'h1D, 0);
        send(8'h01); send(8'h00); send(8'h02); send(8'h00);
        send(8'h10); send(8'h20); send(8'h30);
        send(8'h10); send(8'h20);
        idle();
        chk("pre_reset_pending", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        chk("midrst_valid_out", 32'(valid_out), 0);
        chk("midrst_ready_in", 32'(ready_in), 1);
        chk("midrst_data_out", 32'(data_out), 0);
        chk("midrst_frame_done", 32'(frame_done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_out(8'h01, 0); expect_out(8'h00, 0); expect_out(8'h01, 0); expect_out(8'h00, 0);
        expect_out(8'h80, 1);
        send(8'h01); send(8'h00); send(8'h01); send(8'h00);
        send(8'h80); send(8'h80); send(8'h80);
        idle();
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("frame_done_count", 32'(fd_seen), 32'(exp_fd));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
